// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared entry type and default constants for the fetch queue
package fetch_queue_pkg;

    localparam int FQ_XLEN = 32;
    localparam logic [FQ_XLEN-1:0] FQ_RESET_PC = 32'h0100_0000;
    localparam logic [FQ_XLEN-1:0] FQ_BUBBLE = 32'hffff_ffff;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imemory, redirect and decode-side signals of the fetch queue
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int XLEN  = FQ_XLEN,
    parameter int DEPTH = 4
);
    logic [XLEN-1:0]        imem_addr;
    logic [XLEN-1:0]        imem_rdata;
    logic                   imem_en;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;
    logic                   out_valid;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_inst;
    logic                   deq_ready;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output imem_addr, imem_en, out_valid, out_pc, out_inst, count,
        input  imem_rdata, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_addr, imem_en, out_valid, out_pc, out_inst, count,
        output imem_rdata, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: DEPTH-entry {pc,inst} register file, one write port, async read
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fq_entry_t     i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fq_entry_t     o_rdata
);
    fq_entry_t r_mem [DEPTH];

    // Data contents are not reset; validity is tracked by the control count.
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner with DEPTH-entry decoupling queue toward decode.
// Optional statistics counters enabled by defining FETCH_QUEUE_STATS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = FQ_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = FQ_RESET_PC,
    parameter logic [XLEN-1:0] BUBBLE   = FQ_BUBBLE
) (
    input  logic  clock,
    input  logic  reset,
    fetch_queue_if.master bus
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    fq_entry_t       w_head;
    fq_entry_t       w_wdata;

    assign w_full        = r_count == CW'(DEPTH);
    assign bus.out_valid = (r_count != '0) & !bus.redirect_valid;
    assign w_pop         = bus.out_valid & bus.deq_ready;
    assign w_push        = !bus.redirect_valid & (!w_full | w_pop);
    assign bus.imem_en   = w_push;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.count     = r_count;
    assign bus.out_pc    = bus.out_valid ? w_head.pc : BUBBLE;
    assign bus.out_inst  = bus.out_valid ? w_head.inst : BUBBLE;
    assign w_wdata       = '{pc: r_fetch_pc, inst: bus.imem_rdata};

    fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
        .clock   (clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Pointer, occupancy and fetch PC update; reset beats redirect beats push/pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= bus.redirect_pc & ~XLEN'(3);
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_push ? r_fetch_pc + XLEN'(4) : r_fetch_pc;
            r_wr_ptr   <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr   <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Count full-queue stall cycles and redirect (flush) cycles; both wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + 32'(w_full & !w_pop & !bus.redirect_valid);
            r_flush_count  <= r_flush_count + 32'(bus.redirect_valid);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] BUB = 32'hffff_ffff;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;

    fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );
`else
    fetch_queue #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    always #5 clock = ~clock;

    // imemory: combinational, word depends on address
    assign bus.imem_rdata = bus.imem_addr ^ 32'h5a5a;

    fq_entry_t   m_q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive, check at negedge, update model at the edge
    task automatic cyc(input logic rs, input logic rv, input logic [31:0] rp, input logic dr);
        logic vld, pop, push;
        reset = rs;
        bus.redirect_valid = rv;
        bus.redirect_pc = rp;
        bus.deq_ready = dr;
        #4;
        vld = m_q.size() != 0 && !rv;
        pop = vld && dr;
        push = !rv && (m_q.size() < DEPTH || pop);
        chk("out_valid", 32'(bus.out_valid), 32'(vld));
        chk("out_pc", bus.out_pc, vld ? m_q[0].pc : BUB);
        chk("out_inst", bus.out_inst, vld ? m_q[0].inst : BUB);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_en", 32'(bus.imem_en), 32'(push));
        chk("count", 32'(bus.count), 32'(m_q.size()));
`ifdef FETCH_QUEUE_STATS_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_count", flush_count, m_flush);
`endif
        @(posedge clock);
        if (rs) begin
            m_q.delete();
            m_pc = RST_PC;
            m_stall = 0;
            m_flush = 0;
        end else if (rv) begin
            if (m_q.size() == DEPTH) m_stall = m_stall;
            m_flush++;
            m_q.delete();
            m_pc = {rp[31:2], 2'b00};
        end else begin
            if (m_q.size() == DEPTH && !pop) m_stall++;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back('{pc: m_pc, inst: m_pc ^ 32'h5a5a});
                m_pc += 4;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.deq_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        // reset state with deq_ready held low, then 9 no-drain cycles (5 full stalls)
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0);
        chk("full_hold_addr", bus.imem_addr, 32'h0100_0010);
        for (int i = 0; i < 2; i++) cyc(0, 1, RST_PC, 0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("stall_total", stall_cycles, 32'd5);
        chk("flush_total", flush_count, 32'd2);
`endif
        // streaming: one per cycle
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
        // fill, drain with concurrent push/pop while full
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
        // reach count 3 then redirect to an unaligned target
        cyc(0, 1, RST_PC, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h0100_0103, 0);
        chk("redir_addr", bus.imem_addr, 32'h0100_0100);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        // reset and redirect together: reset wins
        cyc(1, 1, 32'h0200_0000, 1);
        chk("rst_over_redir", bus.imem_addr, RST_PC);
        // fetch_pc wrap at the top of the address space
        cyc(0, 1, 32'hffff_fff8, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(99) == 0, $urandom_range(9) == 0, $urandom, 1'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
